serial3w_responder: RTL and testbench
=====================================

Name: serial3w_responder

Overview:
Device-side responder for the team's 3-wire serial bus (SCLK/CE/DATA, LSB-first, RTC-style command byte) driven by I2C_serial. It holds an 8-byte register file (time/date/control), decodes command bytes, and either captures one write data byte or shifts out one read data byte. It is the on-chip bus-functional peer of the master and serves as the loopback target for set_get_time bring-up. Bus inputs are oversampled on the system clock.

Parameters:
NUM_REGS, 8, register file depth; decoded address range is 0..NUM_REGS-1.
SYNC_STAGES, 2, synchronizer flops on sclk, ce and data_in.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
sclk  input  1  bus serial clock from master
ce  input  1  bus chip enable, active high
data_in  input  1  bus DATA as seen at the pad
data_out  output  1  bit to drive onto DATA
data_oe  output  1  1 = drive DATA; the top level builds the tri-state
dbg_addr  input  3  register peek address
dbg_data  output  8  combinational read of regs[dbg_addr]
wr_strobe  output  1  one-cycle pulse when a register is committed
wr_addr  output  3  address of the commit; valid with wr_strobe
wr_data  output  8  data of the commit; valid with wr_strobe
cmd_err  output  1  one-cycle pulse on an illegal command byte

Behaviour:
- Reset (rst=0, async): state IDLE, bit count 0, shift registers 0, all regs 0x00. data_out=0, data_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, cmd_err=0.
- Sync: sclk, ce and data_in pass through SYNC_STAGES flops. Edge detect on synced sclk gives rise/fall pulses. Sync plus edge latency is SYNC_STAGES+1 cycles. Legal SCLK high and low phases are each >= SYNC_STAGES+2 clk cycles.
- Command byte: bit7=1 required. bit6=1 selects RAM, which is unsupported and treated as out of range. bits5:1 = address. bit0: 1=read, 0=write.
- States:
  - IDLE: wait for synced ce=1, then go to CMD with count=0.
  - CMD: on each rise, shift data_in into bit[count]. After the 8th rise, decode. If bit7=0: pulse cmd_err and go to HOLD. Otherwise go to WDATA (write) or RDATA (read).
  - WDATA: on each rise, shift in one bit. After the 8th rise, the commit follows one cycle later:
    - regs[addr] <= byte, wr_strobe=1, wr_addr/wr_data set.
    - Suppressed (no strobe) if the address is out of range, or if WP=regs[7][7]=1 and addr!=7.
    - Then go to HOLD.
  - RDATA: load the shift register with regs[addr] at decode time, or 0x00 if out of range.
    - On the fall following the 8th command rise: data_oe=1, data_out=bit0.
    - Each subsequent fall presents the next bit.
    - The fall after bit7 has been presented: data_oe=0, go to HOLD.
  - HOLD: ignore sclk; data_oe=0; wait for ce=0.
- From any state, synced ce=0: go to IDLE next cycle. data_oe=0, count cleared, any partial write discarded (no commit, no strobe).
- ce rising while sclk is high: the first rise is not counted until sclk has gone low and high again.
- A write to reg 7 is always permitted, so WP can be cleared.
- Simultaneous events:
  - A commit and a ce drop in the same cycle: the commit wins, because the 8th rise was already seen.
  - A dbg read during a commit cycle returns the old value.
- Reset mid-transfer: immediate return to the reset state; DATA is released asynchronously.

Decomposition:
- Shared package serial3w_pkg:
  - state enum (IDLE, CMD, WDATA, RDATA, HOLD)
  - CMD_VALID_BIT=7, CMD_RAM_BIT=6, CMD_RW_BIT=0
  - WP_REG=7, WP_BIT=7
- One sub-module: serial3w_sync_edge. It contains the SYNC_STAGES synchronizers for sclk/ce/data_in and outputs sclk_rise, sclk_fall, ce_s and din_s.
- The FSM, register file and shifter stay in the top module.

Test Plan:
- Reset, then a dbg sweep of addrs 0..7 -> all 0x00. data_oe=0 throughout.
- Write cmd 0x84 + data 0x23 -> one wr_strobe with wr_addr=2, wr_data=0x23. Then read cmd 0x85 -> DATA returns 0x23 LSB-first, data_oe high for exactly 8 falling-edge slots, then low.
- Write 0x8E/0x80 (set WP), then 0x84/0x55 -> no strobe, reg2 stays 0x23. Then 0x8E/0x00 -> strobe, WP cleared. Then 0x84/0x55 -> reg2=0x55.
- Cmd byte 0x04 (bit7=0) -> one cmd_err pulse, no data_oe, and nothing further until ce drops.
- Read with RAM bit set (0xC1) -> returns 0x00. Write 0xC0/0xFF -> no strobe.
- Drop ce after 4 write-data bits, then rst=0 mid-RDATA -> no commit; data_oe=0 within SYNC_STAGES+1 cycles (immediately for rst). The next full transaction behaves normally.

Source files
------------

// File: rtl/serial3w_pkg.sv
// Shared types and command-byte field positions for the 3-wire serial responder.
package serial3w_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StWdata,
    StRdata,
    StHold
  } state_e;

  localparam int unsigned CMD_VALID_BIT = 7;
  localparam int unsigned CMD_RAM_BIT   = 6;
  localparam int unsigned CMD_RW_BIT    = 0;

  localparam logic [2:0]  WP_REG = 3'd7;
  localparam int unsigned WP_BIT = 7;

endpackage

// File: rtl/serial3w_sync_edge.sv
// Synchronizes the asynchronous bus pins to clk and derives one-cycle sclk edge pulses.
module serial3w_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic ce,
  input  logic data_in,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ce_s,
  output logic din_s
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, ce_sync_q, din_sync_q;
  logic                   sclk_prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      ce_sync_q   <= '0;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], ce};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], data_in};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  // data travels through the same depth as sclk so it is aligned with the rise pulse
  always_comb begin
    sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
    ce_s      = ce_sync_q[SYNC_STAGES-1];
    din_s     = din_sync_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/serial3w_responder.sv
// Device-side responder for the 3-wire serial bus: command decode, 8-byte register
// file with write protect, single-byte write capture and LSB-first read shift-out.
module serial3w_responder
  import serial3w_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ce,
  input  logic       data_in,
  output logic       data_out,
  output logic       data_oe,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       wr_strobe,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cmd_err
);

  logic sclk_rise, sclk_fall, ce_s, din_s;

  serial3w_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ce       (ce),
    .data_in  (data_in),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall),
    .ce_s     (ce_s),
    .din_s    (din_s)
  );

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] addr_q, addr_d;
  logic       ok_q, ok_d;
  logic       commit_q, commit_d;
  logic [2:0] waddr_q, waddr_d;
  logic [7:0] wbyte_q, wbyte_d;
  logic       cmd_err_q, cmd_err_d;
  logic       dout_q, dout_d;
  logic       doe_q, doe_d;
  logic [7:0] regs_q [NUM_REGS];

  logic [7:0] full_byte;
  logic       in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      ok_q      <= 1'b0;
      commit_q  <= 1'b0;
      waddr_q   <= '0;
      wbyte_q   <= '0;
      cmd_err_q <= 1'b0;
      dout_q    <= 1'b0;
      doe_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      ok_q      <= ok_d;
      commit_q  <= commit_d;
      waddr_q   <= waddr_d;
      wbyte_q   <= wbyte_d;
      cmd_err_q <= cmd_err_d;
      dout_q    <= dout_d;
      doe_q     <= doe_d;
      if (commit_q) regs_q[waddr_q] <= wbyte_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    ok_d      = ok_q;
    commit_d  = 1'b0;
    waddr_d   = waddr_q;
    wbyte_d   = wbyte_q;
    cmd_err_d = 1'b0;
    dout_d    = dout_q;
    doe_d     = doe_q;
    // byte as it stands once the current (8th) bit is merged in
    full_byte = {din_s, shift_q[6:0]};
    in_range  = !full_byte[CMD_RAM_BIT] && (32'(full_byte[5:1]) < NUM_REGS);

    unique case (state_q)
      StIdle: begin
        doe_d = 1'b0;
        if (ce_s) begin
          state_d = StCmd;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      StCmd: begin
        if (sclk_rise) begin
          shift_d[cnt_q[2:0]] = din_s;
          cnt_d               = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            shift_d = '0;
            if (!full_byte[CMD_VALID_BIT]) begin
              cmd_err_d = 1'b1;
              state_d   = StHold;
            end else begin
              addr_d = full_byte[3:1];
              ok_d   = in_range;
              if (full_byte[CMD_RW_BIT]) begin
                state_d = StRdata;
                shift_d = in_range ? regs_q[full_byte[3:1]] : 8'h00;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
      end
      StWdata: begin
        if (sclk_rise) begin
          shift_d[cnt_q[2:0]] = din_s;
          cnt_d               = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            state_d = StHold;
            // register 7 stays writable so the protect bit can always be cleared
            if (ok_q && (!regs_q[WP_REG][WP_BIT] || addr_q == WP_REG)) begin
              commit_d = 1'b1;
              waddr_d  = addr_q;
              wbyte_d  = full_byte;
            end
          end
        end
      end
      StRdata: begin
        if (sclk_fall) begin
          if (!cnt_q[3]) begin
            doe_d   = 1'b1;
            dout_d  = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            cnt_d   = cnt_q + 4'd1;
          end else begin
            doe_d   = 1'b0;
            cnt_d   = '0;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        doe_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // a pending commit is left alone: its 8th rise was already seen
    if (!ce_s) begin
      state_d = StIdle;
      cnt_d   = '0;
      doe_d   = 1'b0;
    end
  end

  always_comb begin
    data_out  = dout_q;
    data_oe   = doe_q;
    wr_strobe = commit_q;
    wr_addr   = waddr_q;
    wr_data   = wbyte_q;
    cmd_err   = cmd_err_q;
    dbg_data  = regs_q[dbg_addr];
  end

endmodule

// File: tb/tb_serial3w_responder.sv
// Directed bench: bit-bangs the 3-wire bus and checks commits, read-back, write protect,
// illegal commands, aborted transfers and reset against hand-computed values.
module tb_serial3w_responder;

  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       ce = 1'b0;
  logic       data_in = 1'b0;
  logic       data_out, data_oe;
  logic [2:0] dbg_addr = 3'd0;
  logic [7:0] dbg_data;
  logic       wr_strobe;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       cmd_err;

  int checks = 0;
  int failures = 0;

  int         strobe_cnt = 0;
  int         err_cnt = 0;
  int         oe_cycles = 0;
  logic [2:0] last_waddr = 3'd0;
  logic [7:0] last_wdata = 8'd0;

  always #5 clk = ~clk;

  serial3w_responder dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .ce       (ce),
    .data_in  (data_in),
    .data_out (data_out),
    .data_oe  (data_oe),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cmd_err  (cmd_err)
  );

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      last_waddr <= wr_addr;
      last_wdata <= wr_data;
    end
    if (cmd_err) err_cnt <= err_cnt + 1;
    if (data_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      data_in = b[i];
      wait_cyc(H);
      sclk = 1'b1;
      wait_cyc(H);
      sclk = 1'b0;
    end
  endtask

  task automatic read_byte(output logic [7:0] v, output int hi, output logic oe_after);
    v  = 8'h00;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(H);
      v[i] = data_out;
      if (data_oe) hi++;
      sclk = 1'b1;
      wait_cyc(H);
      sclk = 1'b0;
    end
    wait_cyc(H);
    oe_after = data_oe;
  endtask

  task automatic write_txn(input logic [7:0] cmd, input logic [7:0] dat);
    ce = 1'b1;
    wait_cyc(H);
    send_bits(cmd, 8);
    send_bits(dat, 8);
    wait_cyc(H);
    ce = 1'b0;
    wait_cyc(2 * H);
  endtask

  task automatic read_txn(input logic [7:0] cmd, output logic [7:0] v, output int hi,
                          output logic oe_after);
    ce = 1'b1;
    wait_cyc(H);
    send_bits(cmd, 8);
    read_byte(v, hi, oe_after);
    ce = 1'b0;
    wait_cyc(2 * H);
  endtask

  task automatic peek(input logic [2:0] a, output logic [7:0] v);
    @(negedge clk);
    dbg_addr = a;
    #1;
    v = dbg_data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    int         hi;
    int         s0;
    int         e0;
    int         o0;
    logic       oe_after;
    logic       seen;

    // reset state
    wait_cyc(4);
    check_eq("rst_data_oe", data_oe, 0);
    check_eq("rst_data_out", data_out, 0);
    check_eq("rst_wr_strobe", wr_strobe, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_cmd_err", cmd_err, 0);
    rst = 1'b1;
    wait_cyc(4);
    for (int a = 0; a < 8; a++) begin
      peek(3'(a), v);
      check_eq($sformatf("rst_reg%0d", a), v, 8'h00);
    end
    check_eq("rst_oe_cycles", oe_cycles, 0);

    // write reg2 = 0x23, then read it back
    s0 = strobe_cnt;
    write_txn(8'h84, 8'h23);
    check_eq("w23_strobes", strobe_cnt - s0, 1);
    check_eq("w23_addr", last_waddr, 3'd2);
    check_eq("w23_data", last_wdata, 8'h23);
    peek(3'd2, v);
    check_eq("w23_reg2", v, 8'h23);
    read_txn(8'h85, v, hi, oe_after);
    check_eq("r23_value", v, 8'h23);
    check_eq("r23_oe_slots", hi, 8);
    check_eq("r23_oe_after", oe_after, 0);

    // write protect
    s0 = strobe_cnt;
    write_txn(8'h8E, 8'h80);
    check_eq("wp_set_strobe", strobe_cnt - s0, 1);
    peek(3'd7, v);
    check_eq("wp_set_reg7", v, 8'h80);
    s0 = strobe_cnt;
    write_txn(8'h84, 8'h55);
    check_eq("wp_block_strobe", strobe_cnt - s0, 0);
    peek(3'd2, v);
    check_eq("wp_block_reg2", v, 8'h23);
    s0 = strobe_cnt;
    write_txn(8'h8E, 8'h00);
    check_eq("wp_clr_strobe", strobe_cnt - s0, 1);
    check_eq("wp_clr_addr", last_waddr, 3'd7);
    peek(3'd7, v);
    check_eq("wp_clr_reg7", v, 8'h00);
    write_txn(8'h84, 8'h55);
    peek(3'd2, v);
    check_eq("wp_off_reg2", v, 8'h55);

    // illegal command: one cmd_err, then bus ignored until ce drops
    s0 = strobe_cnt;
    e0 = err_cnt;
    o0 = oe_cycles;
    ce = 1'b1;
    wait_cyc(H);
    send_bits(8'h04, 8);
    send_bits(8'hFF, 8);
    send_bits(8'h00, 8);
    ce = 1'b0;
    wait_cyc(2 * H);
    check_eq("bad_cmd_err", err_cnt - e0, 1);
    check_eq("bad_cmd_oe", oe_cycles - o0, 0);
    check_eq("bad_cmd_strobe", strobe_cnt - s0, 0);

    // RAM bit: read returns zero, write is dropped
    read_txn(8'hC1, v, hi, oe_after);
    check_eq("ram_read", v, 8'h00);
    check_eq("ram_oe_slots", hi, 8);
    s0 = strobe_cnt;
    write_txn(8'hC0, 8'hFF);
    check_eq("ram_write_strobe", strobe_cnt - s0, 0);
    peek(3'd0, v);
    check_eq("ram_write_reg0", v, 8'h00);

    // ce drop after four data bits discards the write
    s0 = strobe_cnt;
    ce = 1'b1;
    wait_cyc(H);
    send_bits(8'h84, 8);
    send_bits(8'hAA, 4);
    ce = 1'b0;
    wait_cyc(3 * H);
    check_eq("abort_strobe", strobe_cnt - s0, 0);
    peek(3'd2, v);
    check_eq("abort_reg2", v, 8'h55);

    // ce drop mid-read releases DATA within SYNC_STAGES+1 cycles
    ce = 1'b1;
    wait_cyc(H);
    send_bits(8'h85, 8);
    wait_cyc(H);
    check_eq("cedrop_oe_before", data_oe, 1);
    ce = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("cedrop_oe_after", data_oe, 0);
    wait_cyc(2 * H);

    // reset mid-read releases DATA at once and clears the register file
    ce = 1'b1;
    wait_cyc(H);
    send_bits(8'h85, 8);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      wait_cyc(1);
      seen = data_oe;
    end
    check_eq("rstmid_oe_before", seen, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rstmid_oe_after", data_oe, 0);
    check_eq("rstmid_reg2", dbg_data, 8'h00);
    ce = 1'b0;
    wait_cyc(4);
    rst = 1'b1;
    wait_cyc(4);

    // normal traffic after reset
    s0 = strobe_cnt;
    write_txn(8'h84, 8'h3C);
    check_eq("post_strobe", strobe_cnt - s0, 1);
    check_eq("post_wdata", last_wdata, 8'h3C);
    read_txn(8'h85, v, hi, oe_after);
    check_eq("post_read", v, 8'h3C);
    check_eq("post_oe_slots", hi, 8);
    check_eq("post_oe_after", oe_after, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
